// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - dual-dispatch, dual-retire in-order reorder buffer
// Optional macro ROB_FLUSH_EN adds a flush input that empties the buffer.
module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int PREG_W = 6,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef ROB_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              disp_valid1,
  input  logic [PREG_W-1:0] disp_dest1,
  input  logic [PREG_W-1:0] disp_old1,
  input  logic [PC_W-1:0]   disp_pc1,
  input  logic              disp_valid2,
  input  logic [PREG_W-1:0] disp_dest2,
  input  logic [PREG_W-1:0] disp_old2,
  input  logic [PC_W-1:0]   disp_pc2,
  output logic              disp_ready,
  output logic [IDX_W-1:0]  alloc_idx1,
  output logic [IDX_W-1:0]  alloc_idx2,
  output logic [DEPTH-1:0]  rob_free,
  input  logic              cmp_valid1,
  input  logic [IDX_W-1:0]  cmp_idx1,
  input  logic              cmp_valid2,
  input  logic [IDX_W-1:0]  cmp_idx2,
  output logic              ret_valid1,
  output logic [PREG_W-1:0] ret_dest1,
  output logic [PREG_W-1:0] ret_old1,
  output logic [PC_W-1:0]   ret_pc1,
  output logic              ret_valid2,
  output logic [PREG_W-1:0] ret_dest2,
  output logic [PREG_W-1:0] ret_old2,
  output logic [PC_W-1:0]   ret_pc2
);

  // Two slots must be free so a dual dispatch never needs a partial accept.
  localparam logic [IDX_W:0] READY_MAX = (IDX_W+1)'(DEPTH - 2);

  logic [IDX_W-1:0]  head;
  logic [IDX_W-1:0]  tail;
  logic [IDX_W-1:0]  headPlus1;
  logic [IDX_W-1:0]  tailPlus1;
  logic [IDX_W:0]    count;
  logic [IDX_W:0]    allocCnt;
  logic [IDX_W:0]    retireCnt;
  logic [DEPTH-1:0]  valid;
  logic [DEPTH-1:0]  done;
  logic [DEPTH-1:0]  validNext;
  logic [DEPTH-1:0]  doneNext;
  logic [PREG_W-1:0] destMem [DEPTH];
  logic [PREG_W-1:0] oldMem  [DEPTH];
  logic [PC_W-1:0]   pcMem   [DEPTH];
  logic              flushNow;
  logic              alloc1;
  logic              alloc2;
  logic              retire1;
  logic              retire2;

`ifdef ROB_FLUSH_EN
  assign flushNow = flush;
`else
  assign flushNow = 1'b0;
`endif

  assign headPlus1  = head + 1'b1;
  assign tailPlus1  = tail + 1'b1;
  assign disp_ready = (count <= READY_MAX);
  assign alloc_idx1 = tail;
  assign alloc_idx2 = tailPlus1;
  assign rob_free   = ~valid;

  assign alloc1  = disp_ready & disp_valid1 & ~flushNow;
  assign alloc2  = alloc1 & disp_valid2;
  assign retire1 = valid[head] & done[head] & ~flushNow;
  assign retire2 = retire1 & valid[headPlus1] & done[headPlus1];

  assign allocCnt  = {{IDX_W{1'b0}}, alloc1} + {{IDX_W{1'b0}}, alloc2};
  assign retireCnt = {{IDX_W{1'b0}}, retire1} + {{IDX_W{1'b0}}, retire2};

  // Retired head entries and freshly allocated tail entries never overlap,
  // and completions only land on entries that are already valid.
  always_comb begin
    validNext = valid;
    doneNext  = done;
    if (cmp_valid1 && valid[cmp_idx1]) doneNext[cmp_idx1] = 1'b1;
    if (cmp_valid2 && valid[cmp_idx2]) doneNext[cmp_idx2] = 1'b1;
    if (retire1) begin
      validNext[head] = 1'b0;
      doneNext[head]  = 1'b0;
    end
    if (retire2) begin
      validNext[headPlus1] = 1'b0;
      doneNext[headPlus1]  = 1'b0;
    end
    if (alloc1) begin
      validNext[tail] = 1'b1;
      doneNext[tail]  = 1'b0;
    end
    if (alloc2) begin
      validNext[tailPlus1] = 1'b1;
      doneNext[tailPlus1]  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      valid      <= '0;
      done       <= '0;
      ret_valid1 <= 1'b0;
      ret_dest1  <= '0;
      ret_old1   <= '0;
      ret_pc1    <= '0;
      ret_valid2 <= 1'b0;
      ret_dest2  <= '0;
      ret_old2   <= '0;
      ret_pc2    <= '0;
    end else if (flushNow) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      valid      <= '0;
      done       <= '0;
      ret_valid1 <= 1'b0;
      ret_dest1  <= '0;
      ret_old1   <= '0;
      ret_pc1    <= '0;
      ret_valid2 <= 1'b0;
      ret_dest2  <= '0;
      ret_old2   <= '0;
      ret_pc2    <= '0;
    end else begin
      head       <= head + retireCnt[IDX_W-1:0];
      tail       <= tail + allocCnt[IDX_W-1:0];
      count      <= count + allocCnt - retireCnt;
      valid      <= validNext;
      done       <= doneNext;
      ret_valid1 <= retire1;
      ret_dest1  <= retire1 ? destMem[head] : '0;
      ret_old1   <= retire1 ? oldMem[head]  : '0;
      ret_pc1    <= retire1 ? pcMem[head]   : '0;
      ret_valid2 <= retire2;
      ret_dest2  <= retire2 ? destMem[headPlus1] : '0;
      ret_old2   <= retire2 ? oldMem[headPlus1]  : '0;
      ret_pc2    <= retire2 ? pcMem[headPlus1]   : '0;
    end
  end

  // Payload storage needs no reset; valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (alloc1) begin
      destMem[tail] <= disp_dest1;
      oldMem[tail]  <= disp_old1;
      pcMem[tail]   <= disp_pc1;
    end
    if (alloc2) begin
      destMem[tailPlus1] <= disp_dest2;
      oldMem[tailPlus1]  <= disp_old2;
      pcMem[tailPlus1]   <= disp_pc2;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - bench for reorder_buffer against a queue-based program-order model
module tb_reorder_buffer;
  localparam int DEPTH  = 16;
  localparam int IDX_W  = 4;
  localparam int PREG_W = 6;
  localparam int PC_W   = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              disp_valid1 = 1'b0, disp_valid2 = 1'b0;
  logic [PREG_W-1:0] disp_dest1 = '0, disp_old1 = '0, disp_dest2 = '0, disp_old2 = '0;
  logic [PC_W-1:0]   disp_pc1 = '0, disp_pc2 = '0;
  logic              disp_ready;
  logic [IDX_W-1:0]  alloc_idx1, alloc_idx2;
  logic [DEPTH-1:0]  rob_free;
  logic              cmp_valid1 = 1'b0, cmp_valid2 = 1'b0;
  logic [IDX_W-1:0]  cmp_idx1 = '0, cmp_idx2 = '0;
  logic              ret_valid1, ret_valid2;
  logic [PREG_W-1:0] ret_dest1, ret_old1, ret_dest2, ret_old2;
  logic [PC_W-1:0]   ret_pc1, ret_pc2;
  bit                flushReq = 1'b0;
`ifdef ROB_FLUSH_EN
  logic              flush = 1'b0;
`endif

  reorder_buffer #(.DEPTH(DEPTH), .IDX_W(IDX_W), .PREG_W(PREG_W), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef ROB_FLUSH_EN
    .flush(flush),
`endif
    .disp_valid1(disp_valid1), .disp_dest1(disp_dest1), .disp_old1(disp_old1), .disp_pc1(disp_pc1),
    .disp_valid2(disp_valid2), .disp_dest2(disp_dest2), .disp_old2(disp_old2), .disp_pc2(disp_pc2),
    .disp_ready(disp_ready), .alloc_idx1(alloc_idx1), .alloc_idx2(alloc_idx2), .rob_free(rob_free),
    .cmp_valid1(cmp_valid1), .cmp_idx1(cmp_idx1), .cmp_valid2(cmp_valid2), .cmp_idx2(cmp_idx2),
    .ret_valid1(ret_valid1), .ret_dest1(ret_dest1), .ret_old1(ret_old1), .ret_pc1(ret_pc1),
    .ret_valid2(ret_valid2), .ret_dest2(ret_dest2), .ret_old2(ret_old2), .ret_pc2(ret_pc2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDX_W-1:0]  idx;
    logic [PREG_W-1:0] dest;
    logic [PREG_W-1:0] old;
    logic [PC_W-1:0]   pc;
    bit                done;
  } entry_t;

  entry_t           rob[$];
  logic [IDX_W-1:0] tailM = '0;
  int               compared = 0;
  int               mismatched = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    check("rst_ret_valid1", 64'(ret_valid1), 64'(0));
    check("rst_ret_valid2", 64'(ret_valid2), 64'(0));
    check("rst_disp_ready", 64'(disp_ready), 64'(1));
    check("rst_alloc_idx1", 64'(alloc_idx1), 64'(0));
    check("rst_alloc_idx2", 64'(alloc_idx2), 64'(1));
    check("rst_rob_free", 64'(rob_free), 64'(16'hFFFF));
    rob.delete();
    tailM = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock: check pre-edge view, advance the model, then check retire outputs.
  task automatic step(input bit v1, input bit v2,
                      input logic [PREG_W-1:0] d1, input logic [PREG_W-1:0] o1, input logic [PC_W-1:0] p1,
                      input logic [PREG_W-1:0] d2, input logic [PREG_W-1:0] o2, input logic [PC_W-1:0] p2,
                      input bit c1v, input logic [IDX_W-1:0] c1, input bit c2v, input logic [IDX_W-1:0] c2);
    bit               rdy;
    int               r;
    logic [DEPTH-1:0] freeExp;
    entry_t           e, x1, x2;
    disp_valid1 = v1; disp_dest1 = d1; disp_old1 = o1; disp_pc1 = p1;
    disp_valid2 = v2; disp_dest2 = d2; disp_old2 = o2; disp_pc2 = p2;
    cmp_valid1 = c1v; cmp_idx1 = c1; cmp_valid2 = c2v; cmp_idx2 = c2;
`ifdef ROB_FLUSH_EN
    flush = flushReq;
`endif
    rdy = (rob.size() <= DEPTH - 2);
    freeExp = '1;
    foreach (rob[i]) freeExp[rob[i].idx] = 1'b0;
    check("disp_ready", 64'(disp_ready), 64'(rdy));
    check("alloc_idx1", 64'(alloc_idx1), 64'(tailM));
    check("alloc_idx2", 64'(alloc_idx2), 64'(IDX_W'(tailM + 1'b1)));
    check("rob_free", 64'(rob_free), 64'(freeExp));
    r = 0;
    x1 = '{default: '0};
    x2 = '{default: '0};
    if (!flushReq && rob.size() > 0 && rob[0].done) r = 1;
    if (r == 1 && rob.size() > 1 && rob[1].done) r = 2;
    if (r >= 1) x1 = rob[0];
    if (r == 2) x2 = rob[1];
    if (flushReq) begin
      rob.delete();
      tailM = '0;
    end else begin
      foreach (rob[i])
        if ((c1v && rob[i].idx == c1) || (c2v && rob[i].idx == c2)) rob[i].done = 1'b1;
      for (int k = 0; k < r; k++) void'(rob.pop_front());
      if (rdy && v1) begin
        e = '{tailM, d1, o1, p1, 1'b0};
        rob.push_back(e);
        tailM = tailM + 1'b1;
        if (v2) begin
          e = '{tailM, d2, o2, p2, 1'b0};
          rob.push_back(e);
          tailM = tailM + 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    check("ret_valid1", 64'(ret_valid1), 64'(r >= 1));
    check("ret_valid2", 64'(ret_valid2), 64'(r == 2));
    if (r >= 1) begin
      check("ret_dest1", 64'(ret_dest1), 64'(x1.dest));
      check("ret_old1", 64'(ret_old1), 64'(x1.old));
      check("ret_pc1", 64'(ret_pc1), 64'(x1.pc));
    end
    if (r == 2) begin
      check("ret_dest2", 64'(ret_dest2), 64'(x2.dest));
      check("ret_old2", 64'(ret_old2), 64'(x2.old));
      check("ret_pc2", 64'(ret_pc2), 64'(x2.pc));
    end
  endtask

  task automatic stepRand(input bit v1, input bit v2, input bit c1v, input logic [IDX_W-1:0] c1,
                          input bit c2v, input logic [IDX_W-1:0] c2);
    step(v1, v2, PREG_W'($urandom_range(0, 63)), PREG_W'($urandom_range(0, 63)), $urandom,
         PREG_W'($urandom_range(0, 63)), PREG_W'($urandom_range(0, 63)), $urandom, c1v, c1, c2v, c2);
  endtask

  function automatic logic [IDX_W-1:0] pickIdx();
    if (rob.size() > 0 && $urandom_range(0, 3) != 0)
      return rob[$urandom_range(0, rob.size() - 1)].idx;
    return IDX_W'($urandom_range(0, DEPTH - 1));
  endfunction

  initial begin
    logic [IDX_W-1:0] freeIdx;
    #2;
    doReset();

    // First pair: dest 10/11, old 3/4, no completion.
    step(1'b1, 1'b1, 6'd10, 6'd3, 32'h100, 6'd11, 6'd4, 32'h104, 1'b0, '0, 1'b0, '0);
    // Complete idx1 only, then idx0; both retire together two edges later.
    stepRand(1'b0, 1'b0, 1'b1, 4'd1, 1'b0, '0);
    stepRand(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, '0);
    stepRand(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    stepRand(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);

    // Fill to DEPTH, then retire two while a pair is held off.
    for (int i = 0; i < 8; i++) stepRand(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
    stepRand(1'b1, 1'b1, 1'b1, rob[0].idx, 1'b1, rob[1].idx);
    stepRand(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
    stepRand(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);

    // Slot 2 without slot 1 allocates nothing.
    stepRand(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    stepRand(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);

    // Drain everything.
    for (int i = 0; i < 40 && rob.size() > 0; i++)
      stepRand(1'b0, 1'b0, 1'b1, rob[0].idx, 1'b1, (rob.size() > 1) ? rob[1].idx : rob[0].idx);
    stepRand(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    check("drained", 64'(rob.size()), 64'(0));

    // Completion to a freed index is ignored; duplicate completion retires once.
    stepRand(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
    freeIdx = tailM + 4'd3;
    stepRand(1'b0, 1'b0, 1'b1, freeIdx, 1'b1, freeIdx);
    stepRand(1'b0, 1'b0, 1'b1, rob[0].idx, 1'b1, rob[0].idx);
    stepRand(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    stepRand(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 3; i++) stepRand(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 4; i++) stepRand(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);

`ifdef ROB_FLUSH_EN
    doReset();
    for (int i = 0; i < 3; i++) stepRand(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
    stepRand(1'b0, 1'b0, 1'b1, rob[0].idx, 1'b1, rob[1].idx);
    flushReq = 1'b1;
    stepRand(1'b1, 1'b1, 1'b1, rob[2].idx, 1'b0, '0);
    flushReq = 1'b0;
    stepRand(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
`endif

    // Randomized traffic with a mid-run reset.
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc == 200) doReset();
      stepRand($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), pickIdx(), 1'($urandom_range(0, 1)), pickIdx());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
